pulse_scheduler: RTL and testbench
==================================

// Module: pulse_scheduler
// PURPOSE
//   Shares one pulse generator among N_REQ requesters. Each granted requester
//   gets one high pulse of programmable width, then a programmable low gap.
//   Sits between requesting blocks and the single pulse line of a test or
//   datapath harness. It replaces free-running per-requester pulse modules.
// PARAMETERS
//   N_REQ   4   number of requesters (>=2)
//   CNT_W   8   width of the width/gap programming fields, in bits
// PORTS
//   clock   in   1              system clock; all state changes on posedge
//   reset   in   1              synchronous reset, active-high
//   req     in   N_REQ          level request per requester; held until granted
//   width   in   CNT_W          pulse high time in clock cycles (0 treated as 1)
//   gap     in   CNT_W          low time after pulse, in cycles (0 = no gap state)
//   grant   out  N_REQ          one-hot, high only in first cycle of owner's pulse
//   signal  out  1              shared pulse output
//   owner   out  $clog2(N_REQ)  index of current/last granted requester
//   busy    out  1              high in PULSE and GAP states
// BEHAVIOUR
//   - Reset values: signal=0, grant=0, busy=0, owner=0, state=IDLE, counters=0.
//     The round-robin pointer is reset so that req[0] has highest priority.
//   - All outputs are registered. FSM states: IDLE, PULSE, GAP.
//   - IDLE, req!=0 at posedge:
//       - arbiter picks winner k: first set bit scanning from last owner+1,
//         wrapping round-robin;
//       - next cycle: state=PULSE, signal=1, grant=1<<k (one cycle only),
//         owner=k, busy=1;
//       - width/gap latched at this edge.
//   - IDLE, req==0: stays IDLE, signal=0.
//   - Request-to-signal latency: 1 cycle.
//   - PULSE: signal high for exactly max(W,1) cycles (W = latched width).
//     Then next state = GAP if latched gap G>0, else IDLE.
//   - GAP: signal=0 for exactly G cycles, then IDLE.
//   - Minimum low time between consecutive pulses: G+1 cycles (includes the
//     mandatory IDLE arbitration cycle).
//   - width/gap changes while busy have no effect until the next grant.
//   - A req drop during owner's PULSE/GAP does not abort: pulse and gap complete.
//   - A req rising while busy waits; it is arbitrated in the next IDLE cycle.
//   - Counters count down from latched value-1. No wrap: CNT_W-bit max value
//     2^CNT_W-1 is a legal width/gap.
//   - Reset in any state: next edge forces the reset values above. A partial
//     pulse is truncated and never resumed.
//   - Simultaneous reset and req: reset wins, no grant.
//   - grant and signal rise in the same cycle. grant never asserts outside PULSE.
// CONFIGURATION
//   PULSE_SCHED_STRICT_PRIO_EN
//     - defined: fixed priority, lowest set req index always wins; the
//       round-robin pointer is removed.
//     - undefined (default): round-robin as described above.
// TESTING
//   1. reset=1 for 2 cycles, req=4'b1111 -> signal=0, grant=0, busy=0, owner=0
//      throughout.
//   2. req=4'b0100 held, width=3, gap=2 -> grant=4'b0100 for 1 cycle;
//      signal=1 for 3 cycles, then 0 for 3 cycles; the next pulse repeats
//      with owner=2.
//   3. req=4'b1111 held, width=1, gap=0 -> grant sequence 0001,0010,0100,1000,
//      0001; signal toggles 1,0 with period 2.
//   4. width=0 -> 1-cycle pulse. width=3, then change width to 5 in pulse
//      cycle 2 -> that pulse stays 3 cycles; the next pulse is 5.
//   5. width=5, assert reset in pulse cycle 2 -> signal=0 next cycle,
//      busy=0. After release with req=4'b1010, grant=4'b0010 first.
//   6. PULSE_SCHED_STRICT_PRIO_EN defined, req=4'b1111 held -> grant is
//      always 4'b0001; owner stays 0.

Source files
------------

// File: rtl/pulse_scheduler_if.sv
// Request/pulse bundle between requesting blocks (master) and pulse_scheduler (slave).
interface pulse_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
);
    localparam int OW = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] gap;
    logic [N_REQ-1:0] grant;
    logic             signal;
    logic [OW-1:0]    owner;
    logic             busy;

    modport master (output req, width, gap, input grant, signal, owner, busy);
    modport slave  (input req, width, gap, output grant, signal, owner, busy);
endinterface

// File: rtl/pulse_scheduler.sv
// Shared pulse generator: arbitrates N_REQ requesters, emits one width/gap pulse per grant.
// Define PULSE_SCHED_STRICT_PRIO_EN for fixed lowest-index priority instead of round-robin.
module pulse_scheduler #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    pulse_scheduler_if.slave  bus
);
    localparam int OW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] gap_q, gap_n;
    logic [OW-1:0]    owner_q, owner_n;
    logic [OW-1:0]    win;
    logic [N_REQ-1:0] grant_q, grant_n;
    logic             signal_q, signal_n;
    logic             busy_q, busy_n;

`ifdef PULSE_SCHED_STRICT_PRIO_EN
    always_comb begin
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (bus.req[i]) win = OW'(i);
    end
`else
    // ptr is the index that currently has highest priority (last owner + 1).
    logic [OW-1:0]      ptr;
    logic [2*N_REQ-1:0] req2;
    logic [N_REQ-1:0]   rot;
    logic [OW:0]        sum;

    always_comb begin
        req2 = {bus.req, bus.req};
        rot  = N_REQ'(req2 >> ptr);
        win  = '0;
        sum  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, ptr} + (OW+1)'(i);
                win = (sum >= (OW+1)'(N_REQ)) ? OW'(sum - (OW+1)'(N_REQ)) : OW'(sum);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            ptr <= '0;
        else if (state == IDLE && |bus.req)
            ptr <= (win == OW'(N_REQ - 1)) ? '0 : win + OW'(1);
    end
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        gap_n    = gap_q;
        owner_n  = owner_q;
        grant_n  = '0;
        signal_n = signal_q;
        busy_n   = busy_q;
        case (state)
            IDLE: begin
                signal_n = 1'b0;
                busy_n   = 1'b0;
                if (|bus.req) begin
                    state_n  = PULSE;
                    signal_n = 1'b1;
                    busy_n   = 1'b1;
                    grant_n  = N_REQ'(1) << win;
                    owner_n  = win;
                    cnt_n    = (bus.width == '0) ? '0 : bus.width - CNT_W'(1);
                    gap_n    = bus.gap;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    signal_n = 1'b0;
                    if (gap_q != '0) begin
                        state_n = GAP;
                        cnt_n   = gap_q - CNT_W'(1);
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            gap_q    <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            signal_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            gap_q    <= gap_n;
            owner_q  <= owner_n;
            grant_q  <= grant_n;
            signal_q <= signal_n;
            busy_q   <= busy_n;
        end
    end

    assign bus.grant  = grant_q;
    assign bus.signal = signal_q;
    assign bus.owner  = owner_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler: per-cycle queue-based reference plus literal scenario checks.
module tb_pulse_scheduler;
    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pulse_scheduler_if #(.N_REQ(4), .CNT_W(8)) bus ();

    pulse_scheduler #(.N_REQ(4), .CNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a granted pulse is a list of future output cycles; empty list = IDLE.
    typedef struct { logic [3:0] g; logic s; } ent_t;
    ent_t       q[$];
    ent_t       ent;
    logic [3:0] e_grant;
    logic       e_sig, e_busy;
    int         e_owner, rr, k, wl;
    bit         cur_idle, mvalid = 0;

    always @(posedge clock) begin
        if (reset) begin
            q.delete();
            e_grant = 0; e_sig = 0; e_busy = 0; e_owner = 0;
            cur_idle = 1; rr = 0; mvalid = 1;
        end else if (mvalid) begin
            if (cur_idle && bus.req != 0) begin
                k = -1;
                for (int i = 0; i < 4; i++)
                    if (k < 0 && bus.req[(rr + i) % 4]) k = (rr + i) % 4;
`ifndef PULSE_SCHED_STRICT_PRIO_EN
                rr = (k + 1) % 4;
`endif
                wl = (bus.width == 0) ? 1 : int'(bus.width);
                for (int i = 0; i < wl; i++) begin
                    ent.g = (i == 0) ? 4'(1 << k) : 4'b0000;
                    ent.s = 1'b1;
                    q.push_back(ent);
                end
                for (int i = 0; i < int'(bus.gap); i++) begin
                    ent.g = 4'b0000; ent.s = 1'b0;
                    q.push_back(ent);
                end
                e_owner = k;
            end
            if (q.size() > 0) begin
                ent = q.pop_front();
                e_grant = ent.g; e_sig = ent.s; e_busy = 1; cur_idle = 0;
            end else begin
                e_grant = 0; e_sig = 0; e_busy = 0; cur_idle = 1;
            end
        end
    end

    always @(negedge clock) begin
        if (mvalid) begin
            chk("cyc_grant", bus.grant, e_grant);
            chk("cyc_signal", bus.signal, e_sig);
            chk("cyc_busy", bus.busy, e_busy);
            chk("cyc_owner", bus.owner, e_owner);
        end
    end

    // Stimulus tasks all start and end on a negedge.
    task automatic wait_grant(output logic [3:0] g);
        int n = 0;
        while (bus.grant == 0 && n < 600) begin n++; @(negedge clock); end
        if (bus.grant == 0) chk("grant_timeout", 0, 1);
        g = bus.grant;
    endtask

    task automatic meas_high(output int h);
        h = 0;
        while (bus.signal && h < 600) begin h++; @(negedge clock); end
    endtask

    task automatic meas_low(output int l);
        l = 0;
        while (!bus.signal && l < 600) begin l++; @(negedge clock); end
    endtask

    logic [3:0] g;
    int         h, l;
    logic [3:0] exp3 [5];

    initial begin
        reset = 1'b1; bus.req = 4'b1111; bus.width = 8'd3; bus.gap = 8'd2;
        repeat (2) @(negedge clock);
        chk("rst_signal", bus.signal, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_owner", bus.owner, 0);

        // single requester, width 3, gap 2
        reset = 1'b0; bus.req = 4'b0100;
        wait_grant(g);  chk("t2_grant", g, 4'b0100);
        meas_high(h);   chk("t2_high", h, 3);
        meas_low(l);    chk("t2_low", l, 3);
        wait_grant(g);  chk("t2_grant2", g, 4'b0100);
        chk("t2_owner", bus.owner, 2);
        bus.req = 4'b0000;
        repeat (8) @(negedge clock);

        // all requesting, width 1, gap 0
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; bus.req = 4'b1111; bus.width = 8'd1; bus.gap = 8'd0;
`ifdef PULSE_SCHED_STRICT_PRIO_EN
        exp3 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        for (int i = 0; i < 5; i++) begin
            wait_grant(g); chk("t3_grant_seq", g, exp3[i]);
`ifdef PULSE_SCHED_STRICT_PRIO_EN
            chk("t6_owner", bus.owner, 0);
`endif
            @(negedge clock);
            chk("t3_toggle_low", bus.signal, 0);
        end
        bus.req = 4'b0000;
        repeat (3) @(negedge clock);

        // width 0 -> 1 cycle; width change mid-pulse deferred
        bus.req = 4'b0001; bus.width = 8'd0; bus.gap = 8'd0;
        wait_grant(g);
        meas_high(h);   chk("t4_w0_high", h, 1);
        bus.width = 8'd3; bus.gap = 8'd1;
        wait_grant(g);
        @(negedge clock);
        bus.width = 8'd5;
        meas_high(h);   chk("t4_w3_high", h + 1, 3);
        meas_low(l);    chk("t4_low", l, 2);
        meas_high(h);   chk("t4_w5_high", h, 5);
        bus.req = 4'b0000;
        repeat (10) @(negedge clock);

        // reset truncates a pulse; pointer restarts at 0
        bus.req = 4'b0100; bus.width = 8'd5; bus.gap = 8'd0;
        wait_grant(g);
        @(negedge clock);
        reset = 1'b1; bus.req = 4'b1010;
        @(negedge clock);
        chk("t5_rst_signal", bus.signal, 0);
        chk("t5_rst_busy", bus.busy, 0);
        chk("t5_rst_grant", bus.grant, 0);
        reset = 1'b0;
        wait_grant(g);  chk("t5_grant", g, 4'b0010);
        chk("t5_owner", bus.owner, 1);
        bus.req = 4'b0000;
        meas_high(h);   chk("t5_high", h, 5);
        repeat (4) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
